// File: rtl/divider_64_bit_seq.sv
// divider_64_bit_seq: unsigned 64-bit restoring divider producing one quotient bit per clock
module divider_64_bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [63:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic [63:0] s;
  logic [64:0] t;
  logic        take;
  assign s           = {r_q[62:0], q_q[63]};
  assign t           = {1'b0, s} + {1'b0, ~d_q} + 65'd1;
  assign take        = r_q[63] | t[64];
  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = state_q == DONE;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
  // Next state: load operands, iterate the trial subtraction, hold the result until taken.
  // A zero divisor loads its fixed result and dwells one cycle in RUN untouched.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        dbz_d   = divisor == 64'd0;
        r_d     = divisor == 64'd0 ? dividend : 64'd0;
        q_d     = divisor == 64'd0 ? '1 : dividend;
        d_d     = divisor;
        cnt_d   = 6'd0;
      end
      RUN: if (dbz_q) state_d = DONE;
      else begin
        r_d     = take ? t[63:0] : s;
        q_d     = {q_q[62:0], take};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'd63 ? DONE : RUN;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule

// File: tb/tb_divider_64_bit_seq.sv
// tb_divider_64_bit_seq: randomized self-checking bench for divider_64_bit_seq
module tb_divider_64_bit_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  int vectors = 0;
  int miscompares = 0;

  divider_64_bit_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic do_div(input logic [63:0] a, input logic [63:0] b, output int cyc, output bit ir_bad);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    ir_bad = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) ir_bad = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic consume(output logic ov, output logic ir);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    ov = out_valid;
    ir = in_ready;
    out_ready = 1'b0;
  endtask

  task automatic check_div(input string name, input logic [63:0] a, input logic [63:0] b);
    int cyc;
    bit ir_bad;
    logic ov, ir;
    logic [63:0] eq, er;
    logic [127:0] recon;
    eq = b == 0 ? '1 : a / b;
    er = b == 0 ? a : a % b;
    do_div(a, b, cyc, ir_bad);
    vectors++;
    if (cyc !== (b == 0 ? 1 : 64)) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, b == 0 ? 1 : 64);
    end
    vectors++;
    if (ir_bad) begin
      miscompares++;
      $display("FAIL %s in_ready_busy: got 1 expected 0 while busy", name);
    end
    vectors++;
    if (quotient !== eq || remainder !== er || div_by_zero !== (b == 0)) begin
      miscompares++;
      $display("FAIL %s result %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
               name, a, b, quotient, remainder, div_by_zero, eq, er, b == 0);
    end
    if (b != 0) begin
      recon = {64'd0, quotient} * {64'd0, b} + {64'd0, remainder};
      vectors++;
      if (recon !== {64'd0, a} || remainder >= b) begin
        miscompares++;
        $display("FAIL %s invariant: got q*d+r=%h r=%h expected %h with r<%h", name, recon, remainder, a, b);
      end
    end
    consume(ov, ir);
    vectors++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      miscompares++;
      $display("FAIL %s handoff: got out_valid=%b in_ready=%b expected 0 1", name, ov, ir);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (quotient !== 64'd0 || remainder !== 64'd0 || out_valid !== 1'b0 || div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got q=%h r=%h ov=%b z=%b ir=%b expected 0 0 0 0 0",
               quotient, remainder, out_valid, div_by_zero, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    check_div("100_7", 64'd100, 64'd7);
    check_div("5_9", 64'd5, 64'd9);
    check_div("overflow", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    check_div("zero_div", 64'h1234_5678_9ABC_DEF0, 64'd0);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ir_bad;
    logic ov, ir;
    logic [63:0] hq, hr;
    do_div(64'd123456789, 64'd1000, cyc, ir_bad);
    hq = quotient;
    hr = remainder;
    vectors++;
    if (hq !== 64'd123456 || hr !== 64'd789) begin
      miscompares++;
      $display("FAIL bp_result: got q=%0d r=%0d expected 123456 789", hq, hr);
    end
    @(negedge clk);
    dividend = 64'd77;
    divisor  = 64'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== hq || remainder !== hr) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b q=%h r=%h expected 1 0 %h %h",
                 i, out_valid, in_ready, quotient, remainder, hq, hr);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume(ov, ir);
    vectors++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", ov, ir);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 64'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || quotient !== 64'd0 || remainder !== 64'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got ov=%b q=%h r=%h ir=%b expected 0 0 0 0", out_valid, quotient, remainder, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_release: got in_ready=%b expected 1", in_ready);
    end
    check_div("after_reset_1000_3", 64'd1000, 64'd3);
  endtask

  task automatic test_throughput();
    int first, second, cyc;
    first = -1;
    second = -1;
    @(negedge clk);
    dividend = 64'd999;
    divisor  = 64'd10;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 200 && second < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (second - first !== 66) begin
      miscompares++;
      $display("FAIL throughput: got period %0d (first=%0d second=%0d) expected 66", second - first, first, second);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL throughput_idle: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0: b = 64'd1;
        1: b = 64'h8000_0000_0000_0000;
        2: b = 64'd0;
        3, 4: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      check_div("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_throughput();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
